// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encodings and the default device ID,
// used by both the responder and the master FSM.
package sccb_pkg;

  localparam logic [6:0] SCCB_SLV_ADDR = 7'h21;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    DEV_ADR   = 4'd1,
    DEV_ACK   = 4'd2,
    SUB_ADR   = 4'd3,
    SUB_ACK   = 4'd4,
    WR_DAT    = 4'd5,
    WR_ACK    = 4'd6,
    RD_DAT    = 4'd7,
    RD_NA     = 4'd8,
    WAIT_STOP = 4'd9
  } sccb_state_t;

endpackage

// File: rtl/sccb_bus_sync.sv
// Two-flop synchronizers for sio_c/sio_d plus edge and START/STOP detection.
// All event outputs are single-cycle pulses, combinational from the synced flops.
module sccb_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sio_c,
  input  logic sio_d,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic       scl_m, sda_m, scl_s, scl_p, sda_p;
  logic [2:0] arm;

  // arm holds off detection until the whole chain reflects the real bus,
  // so reset values of 1 cannot fake a START on a bus that is mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_m <= 1'b1;
      sda_m <= 1'b1;
      scl_s <= 1'b1;
      sda_s <= 1'b1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
      arm   <= '0;
    end else begin
      scl_m <= sio_c;
      sda_m <= sio_d;
      scl_s <= scl_m;
      sda_s <= sda_m;
      scl_p <= scl_s;
      sda_p <= sda_s;
      arm   <= {arm[1:0], 1'b1};
    end
  end

  assign scl_rise  = arm[2] &  scl_s & ~scl_p;
  assign scl_fall  = arm[2] & ~scl_s &  scl_p;
  assign start_det = arm[2] &  scl_s &  scl_p &  sda_p & ~sda_s;
  assign stop_det  = arm[2] &  scl_s &  scl_p & ~sda_p &  sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB slave: decodes device ID, sub-address and data phases into register
// file strobes; serves reads from reg_rdata_i. state_o is a debug view.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter logic [6:0] SLV_ADDR = SCCB_SLV_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sio_c,
  inout  wire               sio_d,
  output logic [DATA_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o,
  output sccb_state_t       state_o
);

  localparam int            CW   = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  sccb_state_t       state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              rw, ack_seen, rd_cap, sda_en, sda_out;
  logic              sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic              byte_done;

  sccb_bus_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sio_c     (sio_c),
    .sio_d     (sio_d),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sio_d     = sda_en ? sda_out : 1'bz;
  assign state_o   = state;
  assign byte_done = scl_fall && (bit_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      rw          <= 1'b0;
      ack_seen    <= 1'b0;
      rd_cap      <= 1'b0;
      sda_en      <= 1'b0;
      sda_out     <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      reg_wr_o <= 1'b0;
      reg_rd_o <= 1'b0;
      rd_cap   <= reg_rd_o;
      if (stop_det) begin
        state   <= IDLE;
        sda_en  <= 1'b0;
        busy_o  <= 1'b0;
        bit_cnt <= '0;
        rd_cap  <= 1'b0;
      end else if (start_det) begin
        state   <= DEV_ADR;
        sda_en  <= 1'b0;
        busy_o  <= 1'b1;
        bit_cnt <= '0;
        rd_cap  <= 1'b0;
      end else begin
        case (state)
          DEV_ADR: begin
            if (scl_rise) begin
              shreg   <= {shreg[DATA_W-2:0], sda_s};
              bit_cnt <= bit_cnt + CW'(1);
            end else if (byte_done) begin
              bit_cnt <= '0;
              if (shreg[DATA_W-1 -: 7] == SLV_ADDR) begin
                rw      <= shreg[DATA_W-8];
                sda_out <= 1'b0;
                sda_en  <= 1'b1;
                state   <= DEV_ACK;
              end else begin
                busy_o <= 1'b0;
                state  <= WAIT_STOP;
              end
            end
          end
          DEV_ACK: begin
            if (scl_fall) begin
              sda_en <= 1'b0;
              if (rw) begin
                reg_rd_o <= 1'b1;
                state    <= RD_DAT;
              end else begin
                state <= SUB_ADR;
              end
            end
          end
          SUB_ADR, WR_DAT: begin
            if (scl_rise) begin
              shreg   <= {shreg[DATA_W-2:0], sda_s};
              bit_cnt <= bit_cnt + CW'(1);
            end else if (byte_done) begin
              bit_cnt <= '0;
              sda_out <= 1'b0;
              sda_en  <= 1'b1;
              if (state == SUB_ADR) begin
                reg_addr_o <= shreg;
                state      <= SUB_ACK;
              end else begin
                reg_wdata_o <= shreg;
                reg_wr_o    <= 1'b1;
                state       <= WR_ACK;
              end
            end
          end
          SUB_ACK: begin
            if (scl_fall) begin
              sda_en <= 1'b0;
              state  <= WR_DAT;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_en     <= 1'b0;
              reg_addr_o <= reg_addr_o + DATA_W'(1);
              state      <= WR_DAT;
            end
          end
          RD_DAT: begin
            // Read data arrives two cycles after entry, well inside the SCL low phase.
            if (rd_cap) begin
              shreg   <= reg_rdata_i;
              sda_out <= reg_rdata_i[DATA_W-1];
              sda_en  <= 1'b1;
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + CW'(1);
            end else if (scl_fall) begin
              if (bit_cnt == LAST) begin
                bit_cnt  <= '0;
                sda_en   <= 1'b0;
                ack_seen <= 1'b0;
                state    <= RD_NA;
              end else begin
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                sda_out <= shreg[DATA_W-2];
              end
            end
          end
          RD_NA: begin
            if (scl_rise) begin
              if (sda_s) state <= WAIT_STOP;
              else       ack_seen <= 1'b1;
            end else if (scl_fall && ack_seen) begin
              reg_addr_o <= reg_addr_o + DATA_W'(1);
              reg_rd_o   <= 1'b1;
              state      <= RD_DAT;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a bit-banged SCCB master, a register
// file stub for reads, and write/read strobe scoreboards.
module tb_sccb_responder;
  import sccb_pkg::*;

  localparam int Q = 10;  // clk cycles per quarter SCL period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sio_c = 1'b1;
  logic        m_sda = 1'b1;
  wire         sio_d;
  logic [7:0]  reg_addr_o, reg_wdata_o, reg_rdata_i = 8'h00;
  logic        reg_wr_o, reg_rd_o, busy_o;
  sccb_state_t state_o;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  rd_exp_q[$];

  pullup (sio_d);
  assign sio_d = m_sda ? 1'bz : 1'b0;

  sccb_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sio_c       (sio_c),
    .sio_d       (sio_d),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o),
    .state_o     (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // register file stub: data valid the cycle after the read strobe
  always @(posedge clk) if (reg_rd_o) reg_rdata_i <= (reg_addr_o == 8'h0A) ? 8'h76 : 8'h5C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboards
  always @(negedge clk) begin
    if (reg_wr_o) begin
      logic [15:0] e;
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(reg_addr_o), 32'(e[15:8]));
        check("wr_data", 32'(reg_wdata_o), 32'(e[7:0]));
      end
    end
    if (reg_rd_o) begin
      rd_cnt++;
      check("rd_expected", 32'(rd_exp_q.size() > 0), 32'd1);
      if (rd_exp_q.size() > 0) check("rd_addr", 32'(reg_addr_o), 32'(rd_exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    sio_c = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    sio_c = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    sio_c = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b; wait_q();
    sio_c = 1'b1; wait_q(); wait_q();
    sio_c = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wait_q();
    sio_c = 1'b1; wait_q();
    b = sio_d; wait_q();
    sio_c = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic       ack;
    logic [7:0] d;

    repeat (4) @(posedge clk);
    #1;
    check("rst_state", 32'(state_o), 32'(IDLE));
    check("rst_addr", 32'(reg_addr_o), 32'h0);
    check("rst_wdata", 32'(reg_wdata_o), 32'h0);
    check("rst_strobes", {30'd0, reg_wr_o, reg_rd_o}, 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_sio_d", 32'(sio_d), 32'h1);
    rst_n = 1'b1;
    wait_q();

    // 3-phase write
    bus_start();
    check("t1_busy", 32'(busy_o), 32'h1);
    write_byte(8'h42, ack); check("t1_dev_ack", 32'(ack), 32'h0);
    write_byte(8'h12, ack); check("t1_sub_ack", 32'(ack), 32'h0);
    exp_q.push_back({8'h12, 8'h80});
    write_byte(8'h80, ack); check("t1_dat_ack", 32'(ack), 32'h0);
    bus_stop();
    check("t1_idle", 32'(state_o), 32'(IDLE));
    check("t1_busy_clr", 32'(busy_o), 32'h0);
    check("t1_wr_cnt", wr_cnt, 32'd1);
    check("t1_addr_inc", 32'(reg_addr_o), 32'h13);

    // set sub-address, then 2-byte read
    bus_start();
    write_byte(8'h42, ack); check("t2_dev_ack", 32'(ack), 32'h0);
    write_byte(8'h0A, ack); check("t2_sub_ack", 32'(ack), 32'h0);
    bus_stop();
    check("t2_addr", 32'(reg_addr_o), 32'h0A);
    rd_exp_q.push_back(8'h0A);
    rd_exp_q.push_back(8'h0B);
    bus_start();
    write_byte(8'h43, ack); check("t2_rd_ack", 32'(ack), 32'h0);
    read_byte(d, 1'b0); check("t2_rdata0", 32'(d), 32'h76);
    read_byte(d, 1'b1); check("t2_rdata1", 32'(d), 32'h5C);
    bus_stop();
    check("t2_rd_cnt", rd_cnt, 32'd2);
    check("t2_idle", 32'(state_o), 32'(IDLE));

    // wrong device ID
    bus_start();
    write_byte(8'h60, ack); check("t3_nack0", 32'(ack), 32'h1);
    check("t3_busy", 32'(busy_o), 32'h0);
    write_byte(8'h55, ack); check("t3_nack1", 32'(ack), 32'h1);
    bus_stop();
    check("t3_idle", 32'(state_o), 32'(IDLE));
    check("t3_strobes", wr_cnt * 16 + rd_cnt, 32'd18);

    // burst write wrapping the sub-address
    bus_start();
    write_byte(8'h42, ack); check("t4_dev_ack", 32'(ack), 32'h0);
    write_byte(8'hFF, ack); check("t4_sub_ack", 32'(ack), 32'h0);
    exp_q.push_back({8'hFF, 8'h11});
    exp_q.push_back({8'h00, 8'h22});
    write_byte(8'h11, ack); check("t4_ack0", 32'(ack), 32'h0);
    write_byte(8'h22, ack); check("t4_ack1", 32'(ack), 32'h0);
    bus_stop();
    check("t4_wr_cnt", wr_cnt, 32'd3);
    check("t4_addr", 32'(reg_addr_o), 32'h01);

    // STOP after 4 data bits
    bus_start();
    write_byte(8'h42, ack); check("t5_dev_ack", 32'(ack), 32'h0);
    write_byte(8'h30, ack); check("t5_sub_ack", 32'(ack), 32'h0);
    for (int i = 0; i < 4; i++) write_bit(i[0]);
    check("t5_in_wr", 32'(state_o), 32'(WR_DAT));
    m_sda = 1'b0; wait_q();
    sio_c = 1'b1; wait_q();
    m_sda = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_idle3", 32'(state_o), 32'(IDLE));
    check("t5_busy", 32'(busy_o), 32'h0);
    wait_q();
    check("t5_no_wr", wr_cnt, 32'd3);
    check("t5_wdata", 32'(reg_wdata_o), 32'h22);

    // reset in the middle of a read
    rd_exp_q.push_back(8'h30);
    bus_start();
    write_byte(8'h43, ack); check("t6_rd_ack", 32'(ack), 32'h0);
    read_bit(ack);
    read_bit(ack);
    check("t6_state", 32'(state_o), 32'(RD_DAT));
    check("t6_driving", 32'(sio_d), 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_sio_d", 32'(sio_d), 32'h1);
    check("t6_state_rst", 32'(state_o), 32'(IDLE));
    check("t6_regs", {reg_addr_o, reg_wdata_o, 14'd0, reg_wr_o, reg_rd_o}, 32'h0);
    check("t6_busy", 32'(busy_o), 32'h0);
    m_sda = 1'b1;
    sio_c = 1'b1;
    wait_q();
    rst_n = 1'b1;
    wait_q();

    // recovery transaction after reset
    bus_start();
    write_byte(8'h42, ack); check("t7_dev_ack", 32'(ack), 32'h0);
    write_byte(8'h05, ack); check("t7_sub_ack", 32'(ack), 32'h0);
    exp_q.push_back({8'h05, 8'h33});
    write_byte(8'h33, ack); check("t7_dat_ack", 32'(ack), 32'h0);
    bus_stop();
    check("t7_wr_cnt", wr_cnt, 32'd4);
    check("t7_rd_cnt", rd_cnt, 32'd3);
    check("exp_q_empty", 32'(exp_q.size() + rd_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning SCCB byte width.
REQ-002 SHALL have parameter SLV_ADDR, default 7'h21, meaning the 7-bit device ID this block answers to.
REQ-003 SHALL have clk  input  1  system clock; one clock; all state on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have sio_c  input  1  SCCB clock from the master.
REQ-006 SHALL have sio_d  inout  1  SCCB data; driven only with 0/1 while the block owns the bus, else 1'bz.
REQ-007 SHALL have reg_addr_o  output  DATA_W  register-file sub-address.
REQ-008 SHALL have reg_wdata_o  output  DATA_W  write data.
REQ-009 SHALL have reg_wr_o  output  1  one-cycle write strobe.
REQ-010 SHALL have reg_rd_o  output  1  one-cycle read strobe.
REQ-011 SHALL have reg_rdata_i  input  DATA_W  read data, valid the cycle after reg_rd_o.
REQ-012 SHALL have busy_o  output  1  high from START to STOP of an addressed transaction.

Function
REQ-013 SHALL sync sio_c and sio_d through two flops each and detect edges on the synced values; bus-event latency is 3 clk cycles.
REQ-014 SHALL detect START as synced sio_d falling while synced sio_c is high, and STOP as synced sio_d rising while synced sio_c is high.
REQ-015 SHALL sample sio_d on synced sio_c rising edges, MSB first, and change its driven sio_d only on synced sio_c falling edges.
REQ-016 SHALL implement states IDLE, DEV_ADR, DEV_ACK, SUB_ADR, SUB_ACK, WR_DAT, WR_ACK, RD_DAT, RD_NA, WAIT_STOP.
REQ-017 SHALL transition IDLE->DEV_ADR on START.
REQ-018 SHALL, after 8 bits in DEV_ADR, compare bits[7:1] with SLV_ADDR: on match go to DEV_ACK; on mismatch go to WAIT_STOP and never drive sio_d.
REQ-019 SHALL drive sio_d=0 during each ACK slot (DEV_ACK, SUB_ACK, WR_ACK), from the falling edge after bit 8 to the falling edge after the 9th clock.
REQ-020 SHALL, from DEV_ACK, go to SUB_ADR when R/W bit = 0, and to RD_DAT when R/W bit = 1.
REQ-021 SHALL, after SUB_ADR's 8 bits, load reg_addr_o and go to SUB_ACK, then WR_DAT.
REQ-022 SHALL, after WR_DAT's 8 bits, load reg_wdata_o, pulse reg_wr_o for one cycle, and go to WR_ACK.
REQ-023 SHALL, after WR_ACK, return to WR_DAT with reg_addr_o incremented modulo 2^DATA_W (wraps 8'hFF->8'h00).
REQ-024 SHALL, on entry to RD_DAT, pulse reg_rd_o with the current reg_addr_o, capture reg_rdata_i the next cycle, and shift it out MSB first; sio_d is released after bit 0.
REQ-025 SHALL, in RD_NA, sample the master's 9th bit: 1 (NA) -> WAIT_STOP; 0 -> increment reg_addr_o and re-enter RD_DAT.
REQ-026 SHALL treat STOP in any state as: release sio_d, go to IDLE, clear busy_o.
REQ-027 SHALL treat START in any state (repeated start) as: release sio_d and restart DEV_ADR with the bit counter cleared; reg_addr_o is kept.
REQ-028 SHALL discard a partial byte aborted by START/STOP and issue no reg_wr_o for it.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force: state IDLE, sio_d=z, reg_addr_o=0, reg_wdata_o=0, reg_wr_o=0, reg_rd_o=0, busy_o=0, synchronizer flops=1.
REQ-030 SHALL ignore a bus that is mid-transaction at reset release until the next START.

Structure
REQ-031 SHALL place state encodings and the default SLV_ADDR in the shared sccb package, which the master FSM also uses.
REQ-032 SHALL put the synchronizer and START/STOP/edge detector in one sub-module, sccb_bus_sync.

Verification
REQ-033 SHALL cover a 3-phase write: ID 0x42, sub 0x12, data 0x80 -> three ACK lows, reg_wr_o once with addr 0x12 / data 0x80.
REQ-034 SHALL cover a 2-phase write of sub 0x0A, then a 2-phase read with ID 0x43 and reg_rdata_i=0x76 -> reg_rd_o with addr 0x0A; 0x76 seen on sio_d MSB first.
REQ-035 SHALL cover a wrong ID 0x60 -> sio_d never driven, no strobes, IDLE after STOP.
REQ-036 SHALL cover a burst write starting at sub 0xFF with data 0x11, 0x22 -> writes to 0xFF then 0x00.
REQ-037 SHALL cover STOP after 4 data bits -> no reg_wr_o, IDLE within 3 cycles.
REQ-038 SHALL cover rst_n low during RD_DAT -> sio_d=z immediately, all outputs at reset values.
